// File: rtl/multdiv_operand_stage_pkg.sv
// rtl/multdiv_operand_stage_pkg.sv - shared state encoding, widths and exception codes for the mult/div operand stage
package multdiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic EXC_NONE = 1'b0;
    localparam logic EXC_FLAG = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_BUSY   = ST_BUSY,
        S_DONE   = ST_DONE
    } state_t;

    function automatic logic is_single_req(input logic mult, input logic div);
        return mult ^ div;
    endfunction

endpackage

// File: rtl/multdiv_operand_stage_if.sv
// rtl/multdiv_operand_stage_if.sv - handshake bundle between the operand stage and the iterative mult/div unit
interface multdiv_operand_stage_if #(
    parameter int WIDTH = 32
);
    logic             unit_start;
    logic             unit_is_div;
    logic [WIDTH-1:0] unit_op_a;
    logic [WIDTH-1:0] unit_op_b;
    logic [WIDTH-1:0] unit_result;
    logic             unit_done;
    logic             unit_exc;

    modport master (
        output unit_start, unit_is_div, unit_op_a, unit_op_b,
        input  unit_result, unit_done, unit_exc
    );

    modport slave (
        input  unit_start, unit_is_div, unit_op_a, unit_op_b,
        output unit_result, unit_done, unit_exc
    );
endinterface

// File: rtl/multdiv_operand_stage_operand_latch.sv
// rtl/multdiv_operand_stage_operand_latch.sv - enable registers holding both operands and the op select
module operand_latch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             is_div_in,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             is_div_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
        end else if (en) begin
            a_q      <= a_in;
            b_q      <= b_in;
            is_div_q <= is_div_in;
        end
    end

endmodule

// File: rtl/multdiv_operand_stage.sv
// rtl/multdiv_operand_stage.sv - launches the iterative mult/div unit and stalls until its result retires; optional watchdog via MULTDIV_TIMEOUT_EN
module multdiv_operand_stage
    import multdiv_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ctrl_mult,
    input  logic                    ctrl_div,
    input  logic [WIDTH-1:0]        operand_a,
    input  logic [WIDTH-1:0]        operand_b,
    multdiv_operand_stage_if.master unit,
    output logic                    stall,
    output logic [WIDTH-1:0]        result_out,
    output logic                    result_valid,
    output logic                    result_exc
);

    state_t           state, state_n;
    logic             latch_en;
    logic             load_res;
    logic [WIDTH-1:0] res_d;
    logic             exc_d;
    logic             timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;

    // Counter is cleared in LAUNCH so it holds the index of the current BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset || state != S_BUSY) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == S_BUSY) && (wd_cnt == WD_LIMIT);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    operand_latch #(.WIDTH(WIDTH)) u_latch (
        .clk       (clk),
        .reset     (reset),
        .en        (latch_en),
        .a_in      (operand_a),
        .b_in      (operand_b),
        .is_div_in (ctrl_div),
        .a_q       (unit.unit_op_a),
        .b_q       (unit.unit_op_b),
        .is_div_q  (unit.unit_is_div)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        latch_en = 1'b0;
        load_res = 1'b0;
        res_d    = '0;
        exc_d    = EXC_NONE;
        case (state)
            S_IDLE: begin
                if (ctrl_mult && ctrl_div) begin
                    state_n  = S_DONE;
                    load_res = 1'b1;
                    exc_d    = EXC_FLAG;
                end else if (ctrl_div && operand_b == '0) begin
                    // Divide-by-zero never reaches the unit but the operands are still captured.
                    latch_en = 1'b1;
                    state_n  = S_DONE;
                    load_res = 1'b1;
                    exc_d    = EXC_FLAG;
                end else if (is_single_req(ctrl_mult, ctrl_div)) begin
                    latch_en = 1'b1;
                    state_n  = S_LAUNCH;
                end
            end
            S_LAUNCH: state_n = S_BUSY;
            S_BUSY: begin
                if (unit.unit_done) begin
                    state_n  = S_DONE;
                    load_res = 1'b1;
                    res_d    = unit.unit_result;
                    exc_d    = unit.unit_exc;
                end else if (timeout_hit) begin
                    state_n  = S_DONE;
                    load_res = 1'b1;
                    exc_d    = EXC_FLAG;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_out <= '0;
            result_exc <= 1'b0;
        end else if (load_res) begin
            result_out <= res_d;
            result_exc <= exc_d;
        end
    end

    assign unit.unit_start = (state == S_LAUNCH);
    assign result_valid    = (state == S_DONE);
    assign stall = ((state == S_IDLE) && (ctrl_mult || ctrl_div)) ||
                   (state == S_LAUNCH) || (state == S_BUSY);

endmodule

// File: tb/tb_multdiv_operand_stage.sv
// tb/tb_multdiv_operand_stage.sv - directed self-checking bench for the mult/div operand stage
module tb_multdiv_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        stall;
    logic [31:0] result_out;
    logic        result_valid;
    logic        result_exc;

    int checks = 0;
    int errors = 0;
    int start_cnt;
    int stall_bad;
    int valid_cnt;

    always #5 clk = ~clk;

    multdiv_operand_stage_if #(.WIDTH(32)) uif ();

    multdiv_operand_stage #(.WIDTH(32), .TIMEOUT_CYCLES(40)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .unit         (uif),
        .stall        (stall),
        .result_out   (result_out),
        .result_valid (result_valid),
        .result_exc   (result_exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0;
        operand_a = '0; operand_b = '0;
        uif.unit_done = 1'b0; uif.unit_result = '0; uif.unit_exc = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_start", uif.unit_start, 0);
        chk("rst_isdiv", uif.unit_is_div, 0);
        chk("rst_opa", uif.unit_op_a, 0);
        chk("rst_opb", uif.unit_op_b, 0);
        chk("rst_result", result_out, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_exc", result_exc, 0);
        chk("rst_stall", stall, 0);

        // multiply 7*6, unit answers in the 32nd BUSY cycle; new request mid-op must be ignored
        ctrl_mult = 1'b1; operand_a = 32'd7; operand_b = 32'd6;
        #1 chk("mul_idle_stall", stall, 1);
        tick();
        chk("mul_launch_start", uif.unit_start, 1);
        chk("mul_launch_stall", stall, 1);
        chk("mul_opa", uif.unit_op_a, 32'd7);
        chk("mul_opb", uif.unit_op_b, 32'd6);
        chk("mul_isdiv", uif.unit_is_div, 0);
        tick();
        start_cnt = 0; stall_bad = 0; valid_cnt = 0;
        for (int i = 1; i <= 32; i++) begin
            operand_a = 32'd99; operand_b = 32'd88;
            if (i == 32) begin uif.unit_done = 1'b1; uif.unit_result = 32'd42; end
            #1;
            start_cnt += int'(uif.unit_start);
            valid_cnt += int'(result_valid);
            if (!stall) stall_bad++;
            tick();
        end
        uif.unit_done = 1'b0; uif.unit_result = 32'hdead;
        chk("mul_busy_starts", start_cnt, 0);
        chk("mul_busy_stall_drop", stall_bad, 0);
        chk("mul_busy_valid", valid_cnt, 0);
        chk("mul_valid", result_valid, 1);
        chk("mul_result", result_out, 32'd42);
        chk("mul_exc", result_exc, 0);
        chk("mul_done_stall", stall, 0);
        chk("mul_hold_opa", uif.unit_op_a, 32'd7);
        chk("mul_hold_opb", uif.unit_op_b, 32'd6);
        ctrl_mult = 1'b0;
        tick();
        chk("mul_after_valid", result_valid, 0);
        chk("mul_after_result", result_out, 32'd42);

        // divide by zero: caught locally
        ctrl_div = 1'b1; operand_a = 32'd100; operand_b = 32'd0;
        #1 chk("dz_idle_stall", stall, 1);
        tick();
        chk("dz_start", uif.unit_start, 0);
        chk("dz_valid", result_valid, 1);
        chk("dz_result", result_out, 0);
        chk("dz_exc", result_exc, 1);
        chk("dz_stall", stall, 0);
        chk("dz_opa", uif.unit_op_a, 32'd100);
        chk("dz_isdiv", uif.unit_is_div, 1);
        ctrl_div = 1'b0;
        tick();
        chk("dz_after_valid", result_valid, 0);

        // both requests: illegal, nothing latched
        ctrl_mult = 1'b1; ctrl_div = 1'b1; operand_a = 32'd5; operand_b = 32'd3;
        tick();
        chk("ill_start", uif.unit_start, 0);
        chk("ill_valid", result_valid, 1);
        chk("ill_exc", result_exc, 1);
        chk("ill_result", result_out, 0);
        chk("ill_opa", uif.unit_op_a, 32'd100);
        chk("ill_opb", uif.unit_op_b, 32'd0);
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        tick();

        // real divide with overflow flag from the unit
        ctrl_div = 1'b1; operand_a = 32'd100; operand_b = 32'd7;
        tick();
        chk("div_start", uif.unit_start, 1);
        chk("div_isdiv", uif.unit_is_div, 1);
        chk("div_opb", uif.unit_op_b, 32'd7);
        ctrl_div = 1'b0;
        tick(); tick();
        uif.unit_done = 1'b1; uif.unit_result = 32'd14; uif.unit_exc = 1'b1;
        tick();
        uif.unit_done = 1'b0; uif.unit_exc = 1'b0;
        chk("div_valid", result_valid, 1);
        chk("div_result", result_out, 32'd14);
        chk("div_exc", result_exc, 1);
        tick();

        // reset in BUSY cycle 5 aborts
        ctrl_mult = 1'b1; operand_a = 32'd11; operand_b = 32'd13;
        tick();
        chk("abt_start", uif.unit_start, 1);
        ctrl_mult = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("abt_busy_stall", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abt_start_low", uif.unit_start, 0);
        chk("abt_stall", stall, 0);
        chk("abt_valid", result_valid, 0);
        chk("abt_opa", uif.unit_op_a, 0);
        chk("abt_opb", uif.unit_op_b, 0);
        chk("abt_result", result_out, 0);
        chk("abt_exc", result_exc, 0);
        valid_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            uif.unit_done = (i == 1);
            #1 valid_cnt += int'(result_valid);
            tick();
        end
        uif.unit_done = 1'b0;
        chk("abt_no_valid", valid_cnt, 0);

        // unit never answers
        ctrl_mult = 1'b1; operand_a = 32'd3; operand_b = 32'd4;
        tick();
        ctrl_mult = 1'b0;
        tick();
        valid_cnt = 0;
`ifdef MULTDIV_TIMEOUT_EN
        for (int i = 1; i <= 40; i++) begin
            valid_cnt += int'(result_valid);
            tick();
        end
        chk("to_no_early_valid", valid_cnt, 0);
        chk("to_valid", result_valid, 1);
        chk("to_exc", result_exc, 1);
        chk("to_result", result_out, 0);
        uif.unit_done = 1'b1; uif.unit_result = 32'd77;
        tick(); tick();
        uif.unit_done = 1'b0;
        chk("to_late_valid", result_valid, 0);
        chk("to_late_result", result_out, 0);
`else
        for (int i = 1; i <= 60; i++) begin
            valid_cnt += int'(result_valid);
            tick();
        end
        chk("hang_no_valid", valid_cnt, 0);
        chk("hang_stall", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("hang_reset_stall", stall, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
